// File: rtl/bus_datapath_core.sv
// rtl/bus_datapath_core.sv - single-bus datapath core with register file, Y/Z staging, HI/LO, ALU and step sequencer
//
// Purpose:
//   NUM_REGS x WIDTH register file sharing one bus with Y (operand A), Z (2*WIDTH ALU result),
//   HI and LO. A built-in sequencer runs rc <= ra OP rb as IDLE -> TA -> TB -> TW -> IDLE,
//   with MUL taking an extra TH step to move Zhi into HI (MUL writes LO/HI, not rc).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        request an op; sampled only in IDLE
//   i_op           000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR, 110 MUL, 111 PASS
//   i_ra/i_rb/i_rc operand A, operand B, destination indices (latched with start)
//   o_busy         sequencer active (registered)
//   o_done         one-cycle pulse when the final write lands (registered)
//   i_ext_we       external register write, honoured only in IDLE
//   i_ext_waddr    external write index
//   i_ext_wdata    external write data
//   i_ext_raddr    external read index
//   o_ext_rdata    combinational R[i_ext_raddr]
//   o_hi_data      HI register
//   o_lo_data      LO register
//   o_bus_out      current bus value

module bus_datapath_core #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int ZERO_R0  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [AW-1:0]    i_ra,
    input  logic [AW-1:0]    i_rb,
    input  logic [AW-1:0]    i_rc,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_ext_we,
    input  logic [AW-1:0]    i_ext_waddr,
    input  logic [WIDTH-1:0] i_ext_wdata,
    input  logic [AW-1:0]    i_ext_raddr,
    output logic [WIDTH-1:0] o_ext_rdata,
    output logic [WIDTH-1:0] o_hi_data,
    output logic [WIDTH-1:0] o_lo_data,
    output logic [WIDTH-1:0] o_bus_out
);

    localparam int AW_S = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TA,
        S_TB,
        S_TW,
        S_TH
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_regs [NUM_REGS];
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_z;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2:0]         r_op;
    logic [AW-1:0]      r_ra;
    logic [AW-1:0]      r_rb;
    logic [AW-1:0]      r_rc;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_rdata_a;
    logic [WIDTH-1:0]   w_rdata_b;
    logic [WIDTH-1:0]   w_rdata_ext;
    logic [WIDTH-1:0]   w_bus;
    logic [AW_S-1:0]    w_shamt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_alu;
    logic               w_ext_wr_ok;
    logic               w_rc_wr_ok;

    // R0 reads as zero when hardwired, regardless of what storage holds.
    always_comb begin
        w_rdata_a   = r_regs[r_ra];
        w_rdata_b   = r_regs[r_rb];
        w_rdata_ext = r_regs[i_ext_raddr];
        if (ZERO_R0 != 0 && r_ra == '0)        w_rdata_a   = '0;
        if (ZERO_R0 != 0 && r_rb == '0)        w_rdata_b   = '0;
        if (ZERO_R0 != 0 && i_ext_raddr == '0) w_rdata_ext = '0;
    end

    assign w_ext_wr_ok = !(ZERO_R0 != 0 && i_ext_waddr == '0);
    assign w_rc_wr_ok  = !(ZERO_R0 != 0 && r_rc == '0);

    // Single shared bus: the driver is chosen purely by the sequencer step.
    always_comb begin
        w_bus = '0;
        case (r_state)
            S_TA:    w_bus = w_rdata_a;
            S_TB:    w_bus = w_rdata_b;
            S_TW:    w_bus = r_z[WIDTH-1:0];
            S_TH:    w_bus = r_z[2*WIDTH-1:WIDTH];
            default: w_bus = '0;
        endcase
    end

    assign w_shamt = w_bus[AW_S-1:0];

    // Explicit sign extension to 2*WIDTH makes the full-width product the signed product.
    assign w_prod = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});

    // B operand is taken straight off the bus during TB; Zhi stays zero except for MUL.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu[WIDTH-1:0] = r_y + w_bus;
            OP_SUB:  w_alu[WIDTH-1:0] = r_y - w_bus;
            OP_AND:  w_alu[WIDTH-1:0] = r_y & w_bus;
            OP_OR:   w_alu[WIDTH-1:0] = r_y | w_bus;
            OP_SHL:  w_alu[WIDTH-1:0] = r_y << w_shamt;
            OP_SHR:  w_alu[WIDTH-1:0] = r_y >> w_shamt;
            OP_MUL:  w_alu = w_prod;
            OP_PASS: w_alu[WIDTH-1:0] = w_bus;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_y    <= '0;
            r_z    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_op   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // External write lands on the same edge that latches start, so TA sees it.
                    if (i_ext_we && w_ext_wr_ok) begin
                        r_regs[i_ext_waddr] <= i_ext_wdata;
                    end
                    if (i_start) begin
                        r_op    <= i_op;
                        r_ra    <= i_ra;
                        r_rb    <= i_rb;
                        r_rc    <= i_rc;
                        r_busy  <= 1'b1;
                        r_state <= S_TA;
                    end
                end
                S_TA: begin
                    r_y     <= w_bus;
                    r_state <= S_TB;
                end
                S_TB: begin
                    r_z     <= w_alu;
                    r_state <= S_TW;
                end
                S_TW: begin
                    if (r_op == OP_MUL) begin
                        r_lo    <= w_bus;
                        r_state <= S_TH;
                    end else begin
                        if (w_rc_wr_ok) begin
                            r_regs[r_rc] <= w_bus;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_TH: begin
                    r_hi    <= w_bus;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ext_rdata = w_rdata_ext;
    assign o_hi_data   = r_hi;
    assign o_lo_data   = r_lo;
    assign o_bus_out   = w_bus;

endmodule
